// File: rtl/assert_monitor_array.sv
// Multi-channel violation monitor: debounced per-channel episode detection, sticky flags,
// saturating event counters, first-event capture with timestamp, and a severity-qualified irq.
module assert_monitor_array #(
    parameter int                  NUM_CH    = 4,
    parameter int                  PERSIST   = 1,
    parameter int                  CNT_W     = 8,
    parameter int                  TS_W      = 16,
    parameter logic [2*NUM_CH-1:0] CH_LEVEL  = '0,
    parameter int                  IRQ_LEVEL = 2,
    localparam int                 CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CH-1:0]       en,
    input  logic [NUM_CH-1:0]       cond,
    input  logic                    clr,
    output logic [NUM_CH-1:0]       sticky,
    output logic [NUM_CH-1:0]       evt,
    output logic [NUM_CH*CNT_W-1:0] cnt,
    output logic                    first_vld,
    output logic [CH_W-1:0]         first_ch,
    output logic [TS_W-1:0]         first_ts,
    output logic                    irq
);

    if (NUM_CH < 1 || NUM_CH > 32) begin : g_bad_num_ch
        $fatal(1, "assert_monitor_array: NUM_CH must be 1..32");
    end
    if (PERSIST < 1 || PERSIST > 255) begin : g_bad_persist
        $fatal(1, "assert_monitor_array: PERSIST must be 1..255");
    end

    localparam logic [7:0] PERSIST_C = 8'(PERSIST);

    typedef enum logic [1:0] {IDLE, PEND, FIRE, HOLD} state_t;

    state_t                   state_q [NUM_CH];
    state_t                   state_d [NUM_CH];
    logic [7:0]               pcnt_q  [NUM_CH];
    logic [7:0]               pcnt_d  [NUM_CH];
    logic [TS_W-1:0]          ts_q, ts_d;
    logic [NUM_CH-1:0]        sticky_q, sticky_d;
    logic [NUM_CH*CNT_W-1:0]  cnt_q, cnt_d;
    logic                     first_vld_q, first_vld_d;
    logic [CH_W-1:0]          first_ch_q, first_ch_d;
    logic [TS_W-1:0]          first_ts_q, first_ts_d;

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            state_d[i] = state_q[i];
            pcnt_d[i]  = pcnt_q[i];
            evt[i]     = (state_q[i] == FIRE);
            case (state_q[i])
                IDLE: begin
                    if (en[i] && cond[i]) begin
                        if (PERSIST == 1) begin
                            state_d[i] = FIRE;
                        end else begin
                            state_d[i] = PEND;
                            pcnt_d[i]  = 8'd1;
                        end
                    end
                end
                PEND: begin
                    if (en[i] && cond[i]) begin
                        if (pcnt_q[i] + 8'd1 == PERSIST_C) begin
                            state_d[i] = FIRE;
                            pcnt_d[i]  = 8'd0;
                        end else begin
                            pcnt_d[i] = pcnt_q[i] + 8'd1;
                        end
                    end else begin
                        state_d[i] = IDLE;
                        pcnt_d[i]  = 8'd0;
                    end
                end
                FIRE: state_d[i] = (en[i] && cond[i]) ? HOLD : IDLE;
                HOLD: if (!(en[i] && cond[i])) state_d[i] = IDLE;
                default: state_d[i] = IDLE;
            endcase
        end
    end

    // clr is applied first so a coincident event re-populates the cleared state
    always_comb begin
        logic [CH_W-1:0] low_ch;
        ts_d        = ts_q + TS_W'(1);
        sticky_d    = sticky_q;
        cnt_d       = cnt_q;
        first_vld_d = first_vld_q;
        first_ch_d  = first_ch_q;
        first_ts_d  = first_ts_q;
        low_ch      = '0;
        if (clr) begin
            sticky_d    = '0;
            cnt_d       = '0;
            first_vld_d = 1'b0;
            first_ch_d  = '0;
            first_ts_d  = '0;
        end
        for (int i = 0; i < NUM_CH; i++) begin
            if (evt[i]) begin
                sticky_d[i] = 1'b1;
                if (cnt_d[i*CNT_W +: CNT_W] != {CNT_W{1'b1}})
                    cnt_d[i*CNT_W +: CNT_W] = cnt_d[i*CNT_W +: CNT_W] + CNT_W'(1);
            end
        end
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (evt[i]) low_ch = CH_W'(i);
        end
        if (!first_vld_d && (|evt)) begin
            first_vld_d = 1'b1;
            first_ch_d  = low_ch;
            first_ts_d  = ts_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i] <= IDLE;
                pcnt_q[i]  <= 8'd0;
            end
            ts_q        <= '0;
            sticky_q    <= '0;
            cnt_q       <= '0;
            first_vld_q <= 1'b0;
            first_ch_q  <= '0;
            first_ts_q  <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i] <= state_d[i];
                pcnt_q[i]  <= pcnt_d[i];
            end
            ts_q        <= ts_d;
            sticky_q    <= sticky_d;
            cnt_q       <= cnt_d;
            first_vld_q <= first_vld_d;
            first_ch_q  <= first_ch_d;
            first_ts_q  <= first_ts_d;
        end
    end

    always_comb begin
        irq = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (int'(CH_LEVEL[2*i +: 2]) >= IRQ_LEVEL && sticky_q[i]) irq = 1'b1;
        end
    end

    assign sticky    = sticky_q;
    assign cnt       = cnt_q;
    assign first_vld = first_vld_q;
    assign first_ch  = first_ch_q;
    assign first_ts  = first_ts_q;

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (evt[i]) begin
                    case (CH_LEVEL[2*i +: 2])
                        2'd0:    $display("ch %0d ts %0d", i, ts_q);
                        2'd1:    $warning("ch %0d ts %0d", i, ts_q);
                        2'd2:    $error("ch %0d ts %0d", i, ts_q);
                        default: $fatal(1, "ch %0d ts %0d", i, ts_q);
                    endcase
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_assert_monitor_array.sv
// Bench for assert_monitor_array: directed episodes plus random traffic compared against a
// run-length model of the monitor (events, sticky, saturating counts, first capture, irq).
module tb_assert_monitor_array;
    localparam int          NUM_CH    = 4;
    localparam int          PERSIST   = 3;
    localparam int          CNT_W     = 2;
    localparam int          TS_W      = 16;
    localparam logic [7:0]  CH_LEVEL  = 8'b00_01_00_01;
    localparam int          IRQ_LEVEL = 1;

    logic              clk, rst, clr;
    logic [3:0]        en, cond;
    logic [3:0]        sticky, evt;
    logic [7:0]        cnt;
    logic              first_vld, irq;
    logic [1:0]        first_ch;
    logic [15:0]       first_ts;

    assert_monitor_array #(
        .NUM_CH(NUM_CH), .PERSIST(PERSIST), .CNT_W(CNT_W), .TS_W(TS_W),
        .CH_LEVEL(CH_LEVEL), .IRQ_LEVEL(IRQ_LEVEL)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .cond(cond), .clr(clr),
        .sticky(sticky), .evt(evt), .cnt(cnt), .first_vld(first_vld),
        .first_ch(first_ch), .first_ts(first_ts), .irq(irq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int failures = 0;

    // reference model state
    int run [4];
    int m_cnt [4];
    int m_lvl [4] = '{1, 0, 1, 0};
    logic [3:0] m_evt, m_sticky;
    logic       m_fvld;
    int         m_fch, m_fts, m_ts;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            run[i] = 0;
            m_cnt[i] = 0;
        end
        m_evt = '0; m_sticky = '0; m_fvld = 1'b0; m_fch = 0; m_fts = 0; m_ts = 0;
    endtask

    task automatic check_all(input string tag);
        logic m_irq;
        m_irq = 1'b0;
        for (int i = 0; i < 4; i++) if (m_lvl[i] >= IRQ_LEVEL && m_sticky[i]) m_irq = 1'b1;
        check({tag, ".evt"}, 32'(evt), 32'(m_evt));
        check({tag, ".sticky"}, 32'(sticky), 32'(m_sticky));
        for (int i = 0; i < 4; i++)
            check($sformatf("%s.cnt%0d", tag, i), 32'(cnt[i*2 +: 2]), 32'(m_cnt[i]));
        check({tag, ".first_vld"}, 32'(first_vld), 32'(m_fvld));
        check({tag, ".first_ch"}, 32'(first_ch), 32'(m_fch));
        check({tag, ".first_ts"}, 32'(first_ts), 32'(m_fts));
        check({tag, ".irq"}, 32'(irq), 32'(m_irq));
    endtask

    // called just after a negedge; drives inputs, advances one edge, updates model, checks
    task automatic tick(input string tag, input logic [3:0] e, input logic [3:0] c, input logic cl);
        logic [3:0] nevt;
        bit found;
        en = e; cond = c; clr = cl;
        @(posedge clk);
        if (cl) begin
            m_sticky = '0; m_fvld = 1'b0; m_fch = 0; m_fts = 0;
            for (int i = 0; i < 4; i++) m_cnt[i] = 0;
        end
        for (int i = 0; i < 4; i++) begin
            if (m_evt[i]) begin
                m_sticky[i] = 1'b1;
                if (m_cnt[i] < (1 << CNT_W) - 1) m_cnt[i]++;
            end
        end
        if (!m_fvld && |m_evt) begin
            found = 0;
            for (int i = 0; i < 4; i++) begin
                if (m_evt[i] && !found) begin
                    m_fch = i;
                    found = 1;
                end
            end
            m_fvld = 1'b1;
            m_fts = m_ts;
        end
        for (int i = 0; i < 4; i++) begin
            if (e[i] && c[i]) begin
                if (run[i] < 1000) run[i]++;
            end else begin
                run[i] = 0;
            end
            nevt[i] = (run[i] == PERSIST);
        end
        m_evt = nevt;
        m_ts = (m_ts + 1) % (1 << TS_W);
        #1;
        check_all(tag);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; en = '0; cond = '0; clr = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        check_all("reset");
        @(negedge clk);
        rst = 1'b0;

        // short violation on ch0 never reaches persistence
        tick("s1", 4'hF, 4'b0001, 0);
        tick("s1", 4'hF, 4'b0001, 0);
        tick("s1", 4'hF, 4'b0000, 0);
        tick("s1", 4'hF, 4'b0000, 0);
        check("s1_no_sticky", 32'(sticky[0]), 32'd0);

        // long episode on ch1 fires once, then a re-armed episode fires again
        for (int k = 0; k < 10; k++) tick("s2a", 4'hF, 4'b0010, 0);
        check("s2_cnt1_once", 32'(cnt[3:2]), 32'd1);
        tick("s2b", 4'hF, 4'b0000, 0);
        for (int k = 0; k < 3; k++) tick("s2c", 4'hF, 4'b0010, 0);
        tick("s2d", 4'hF, 4'b0010, 0);
        check("s2_cnt1_twice", 32'(cnt[3:2]), 32'd2);

        // counter saturation on ch2, also via en gating
        for (int p = 0; p < 5; p++) begin
            for (int k = 0; k < 3; k++) tick("s3", 4'hF, 4'b0100, 0);
            tick("s3", 4'b1011, 4'b0100, 0);
        end
        tick("s3e", 4'hF, 4'b0000, 0);
        check("s3_sat", 32'(cnt[5:4]), 32'd3);

        // simultaneous events on ch3/ch1 after a clear, then ch0 later
        tick("s4clr", 4'hF, 4'b0000, 1);
        for (int k = 0; k < 3; k++) tick("s4a", 4'hF, 4'b1010, 0);
        tick("s4b", 4'hF, 4'b0000, 0);
        check("s4_first_ch", 32'(first_ch), 32'd1);
        for (int k = 0; k < 4; k++) tick("s4c", 4'hF, 4'b0001, 0);
        tick("s4d", 4'hF, 4'b0000, 0);

        // clr coincident with ch0 event, then clr alone
        for (int k = 0; k < 3; k++) tick("s5a", 4'hF, 4'b0001, 0);
        tick("s5b", 4'hF, 4'b0000, 1);
        check("s5_first_ch0", 32'(first_ch), 32'd0);
        tick("s5c", 4'hF, 4'b0000, 1);
        check("s5_irq_off", 32'(irq), 32'd0);

        // reset mid-episode restarts the persistence count
        tick("s6a", 4'hF, 4'b0100, 0);
        tick("s6a", 4'hF, 4'b0100, 0);
        rst = 1'b1;
        #1;
        model_reset();
        check_all("s6rst");
        @(negedge clk);
        rst = 1'b0;
        tick("s6b", 4'hF, 4'b0100, 0);
        tick("s6b", 4'hF, 4'b0100, 0);
        check("s6_no_early_evt", 32'(evt[2]), 32'd0);
        tick("s6c", 4'hF, 4'b0100, 0);
        check("s6_evt", 32'(evt[2]), 32'd1);

        // random traffic
        for (int k = 0; k < 400; k++) begin
            logic [3:0] re, rc;
            for (int i = 0; i < 4; i++) begin
                re[i] = ($urandom_range(0, 9) != 0);
                rc[i] = ($urandom_range(0, 9) < 7);
            end
            tick("rnd", re, rc, ($urandom_range(0, 39) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
